// File: rtl/pong_pkg.sv
// Shared constants for the Pong point referee: state encoding, state width and score limits.
package pong_pkg;

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_IDLE       = 3'd0;
  localparam logic [STATE_W-1:0] ST_SERVE_WAIT = 3'd1;
  localparam logic [STATE_W-1:0] ST_PLAY       = 3'd2;
  localparam logic [STATE_W-1:0] ST_SCORED     = 3'd3;
  localparam logic [STATE_W-1:0] ST_GAME_OVER  = 3'd4;

  localparam int SCORE_W           = 3;
  localparam int MAX_DISPLAY_SCORE = 5;

endpackage

// File: rtl/pong_pulse_stretcher.sv
// Loadable down-counter: a load raises o_pulse on the next edge and holds it for PULSE_CYCLES cycles.
module pong_pulse_stretcher #(
  parameter int PULSE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  output logic o_pulse,
  output logic o_last
);

  localparam int CW = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;

  logic [CW-1:0] r_cnt;
  logic          r_pulse;

  // r_cnt counts the remaining high cycles after the current one
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pulse <= 1'b0;
      r_cnt   <= '0;
    end else if (i_load) begin
      r_pulse <= 1'b1;
      r_cnt   <= CW'(PULSE_CYCLES - 1);
    end else if (r_pulse) begin
      if (r_cnt == '0) begin
        r_pulse <= 1'b0;
      end else begin
        r_cnt <= r_cnt - {{(CW-1){1'b0}}, 1'b1};
      end
    end
  end

  assign o_pulse = r_pulse;
  assign o_last  = r_pulse & (r_cnt == '0);

endmodule

// File: rtl/pong_point_referee.sv
// Pong point referee: debounced point pulses, serve sequencing and game-over detection.
// Optional build macro PONG_REFEREE_PAUSE_EN adds a level-sensitive pause input.
module pong_point_referee
  import pong_pkg::*;
#(
  parameter int PULSE_CYCLES = 4,
  parameter int SERVE_FRAMES = 60,
  parameter int WIN_SCORE    = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               frame_tick,
  input  logic               miss_left,
  input  logic               miss_right,
`ifdef PONG_REFEREE_PAUSE_EN
  input  logic               pause,
`endif
  output logic               point_p1,
  output logic               point_p2,
  output logic               score_rst,
  output logic               ball_hold,
  output logic               serve_dir,
  output logic               game_over,
  output logic               winner,
  output logic [SCORE_W-1:0] score_p1,
  output logic [SCORE_W-1:0] score_p2
);

  if (WIN_SCORE < 1 || WIN_SCORE > MAX_DISPLAY_SCORE) begin : g_bad_win_score
    $error("WIN_SCORE must lie in 1..MAX_DISPLAY_SCORE");
  end

  localparam int                 SCW = $clog2(SERVE_FRAMES + 1);
  localparam logic [SCORE_W-1:0] WIN = SCORE_W'(WIN_SCORE);

  logic               w_pause;
  logic               w_load_p1;
  logic               w_load_p2;
  logic               w_last_p1;
  logic               w_last_p2;
  logic               w_both;
  logic               r_miss_l;
  logic               r_miss_r;
  logic [STATE_W-1:0] r_state;
  logic [SCW-1:0]     r_serve_cnt;
  logic               r_score_rst;
  logic               r_ball_hold;
  logic               r_serve_dir;
  logic               r_game_over;
  logic               r_winner;
  logic [SCORE_W-1:0] r_score_p1;
  logic [SCORE_W-1:0] r_score_p2;

`ifdef PONG_REFEREE_PAUSE_EN
  assign w_pause = pause;
`else
  assign w_pause = 1'b0;
`endif

  // Misses are registered only while actively playing; stale samples clear on leaving PLAY
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_miss_l <= 1'b0;
      r_miss_r <= 1'b0;
    end else begin
      r_miss_l <= miss_left  & (r_state == ST_PLAY) & ~w_pause;
      r_miss_r <= miss_right & (r_state == ST_PLAY) & ~w_pause;
    end
  end

  assign w_both    = (r_state == ST_PLAY) & ~w_pause & r_miss_l & r_miss_r;
  assign w_load_p1 = (r_state == ST_PLAY) & ~w_pause & r_miss_r & ~r_miss_l;
  assign w_load_p2 = (r_state == ST_PLAY) & ~w_pause & r_miss_l & ~r_miss_r;

  pong_pulse_stretcher #(.PULSE_CYCLES(PULSE_CYCLES)) u_stretch_p1 (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load_p1),
    .o_pulse (point_p1),
    .o_last  (w_last_p1)
  );

  pong_pulse_stretcher #(.PULSE_CYCLES(PULSE_CYCLES)) u_stretch_p2 (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load_p2),
    .o_pulse (point_p2),
    .o_last  (w_last_p2)
  );

  // Game FSM with all control outputs registered alongside the state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_serve_cnt <= '0;
      r_score_rst <= 1'b0;
      r_ball_hold <= 1'b1;
      r_serve_dir <= 1'b0;
      r_game_over <= 1'b0;
      r_winner    <= 1'b0;
      r_score_p1  <= '0;
      r_score_p2  <= '0;
    end else begin
      r_score_rst <= 1'b0;
      case (r_state)
        ST_IDLE, ST_GAME_OVER: begin
          r_ball_hold <= 1'b1;
          if (start) begin
            r_state     <= ST_SERVE_WAIT;
            r_score_rst <= 1'b1;
            r_score_p1  <= '0;
            r_score_p2  <= '0;
            r_game_over <= 1'b0;
            r_serve_cnt <= '0;
          end
        end
        ST_SERVE_WAIT: begin
          if (frame_tick && !w_pause) begin
            if (r_serve_cnt == SCW'(SERVE_FRAMES - 1)) begin
              r_state     <= ST_PLAY;
              r_ball_hold <= 1'b0;
              r_serve_cnt <= '0;
            end else begin
              r_serve_cnt <= r_serve_cnt + {{(SCW-1){1'b0}}, 1'b1};
            end
          end
        end
        ST_PLAY: begin
          r_ball_hold <= w_pause;
          if (w_both) begin
            r_state     <= ST_SERVE_WAIT;
            r_ball_hold <= 1'b1;
            r_serve_cnt <= '0;
          end else if (w_load_p1) begin
            r_state     <= ST_SCORED;
            r_ball_hold <= 1'b1;
            r_score_p1  <= r_score_p1 + 3'd1;
            r_serve_dir <= 1'b0;
          end else if (w_load_p2) begin
            r_state     <= ST_SCORED;
            r_ball_hold <= 1'b1;
            r_score_p2  <= r_score_p2 + 3'd1;
            r_serve_dir <= 1'b1;
          end
        end
        ST_SCORED: begin
          // Leave only as the pulse falls, so a new point can never merge with this one
          if (w_last_p1 || w_last_p2) begin
            r_serve_cnt <= '0;
            if (w_last_p1 && r_score_p1 == WIN) begin
              r_state     <= ST_GAME_OVER;
              r_game_over <= 1'b1;
              r_winner    <= 1'b0;
            end else if (w_last_p2 && r_score_p2 == WIN) begin
              r_state     <= ST_GAME_OVER;
              r_game_over <= 1'b1;
              r_winner    <= 1'b1;
            end else begin
              r_state <= ST_SERVE_WAIT;
            end
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_ball_hold <= 1'b1;
        end
      endcase
    end
  end

  assign score_rst = r_score_rst;
  assign ball_hold = r_ball_hold;
  assign serve_dir = r_serve_dir;
  assign game_over = r_game_over;
  assign winner    = r_winner;
  assign score_p1  = r_score_p1;
  assign score_p2  = r_score_p2;

endmodule
